// File: rtl/c_bus_arbiter.sv
// C-bus write-back arbiter: merges NUM_SRC sources onto one registered valid/ready C bus.
// Optional even-parity output OUT_PARITY is enabled by defining C_BUS_ARBITER_PARITY_EN.
module c_bus_arbiter #(
    parameter int BUS_WIDTH = 32,
    parameter int NUM_SRC   = 4,
    parameter int SEL_W     = 2,
    parameter int RR_EN     = 0
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_InHigh,
    input  logic [NUM_SRC-1:0]            IN_VALID,
    input  logic [NUM_SRC*BUS_WIDTH-1:0]  IN_BUS,
    output logic [NUM_SRC-1:0]            IN_READY,
    output logic [BUS_WIDTH-1:0]          BUS_OUT,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [SEL_W-1:0]              OUT_SRC
`ifdef C_BUS_ARBITER_PARITY_EN
    ,
    output logic                          OUT_PARITY
`endif
);

    function automatic logic parity_f(input logic [BUS_WIDTH-1:0] word);
        return ^word;
    endfunction

    logic [BUS_WIDTH-1:0]   bus_q, bus_d;
    logic                   valid_q, valid_d;
    logic [SEL_W-1:0]       src_q, src_d;
    logic [SEL_W-1:0]       ptr_q, ptr_d;
    logic [SEL_W-1:0]       winner_s;
    logic                   found_s;
    logic [SEL_W:0]         sum_s;
    logic [SEL_W:0]         nxt_s;
    logic [2*NUM_SRC-1:0]   dbl_s;
    logic                   load_s;
    logic                   any_s;
    logic                   xfer_s;
    logic [NUM_SRC-1:0]     ready_s;

    assign load_s = !valid_q || OUT_READY;
    assign any_s  = |IN_VALID;
    assign xfer_s = load_s && any_s;

    // Winner select: lowest index, or first request at/after the pointer with wrap.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        sum_s    = '0;
        dbl_s    = {IN_VALID, IN_VALID} >> ptr_q;
        if (RR_EN != 0) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (!found_s && dbl_s[k]) begin
                    sum_s = {1'b0, ptr_q} + (SEL_W+1)'(k);
                    if (sum_s >= (SEL_W+1)'(NUM_SRC)) begin
                        sum_s = sum_s - (SEL_W+1)'(NUM_SRC);
                    end else begin
                        sum_s = sum_s;
                    end
                    winner_s = sum_s[SEL_W-1:0];
                    found_s  = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (IN_VALID[i]) begin
                    winner_s = SEL_W'(i);
                end else begin
                    winner_s = winner_s;
                end
            end
        end
    end

    // One-hot accept to the winner while the output stage can load.
    always_comb begin
        ready_s = '0;
        if (!RESET_InHigh && xfer_s) begin
            ready_s[winner_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign IN_READY = ready_s;

    // Next state of the output stage and round-robin pointer.
    always_comb begin
        bus_d   = bus_q;
        valid_d = valid_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        nxt_s   = {1'b0, winner_s} + {{SEL_W{1'b0}}, 1'b1};
        if (xfer_s) begin
            bus_d   = IN_BUS[winner_s*BUS_WIDTH +: BUS_WIDTH];
            src_d   = winner_s;
            valid_d = 1'b1;
            if (RR_EN != 0) begin
                ptr_d = (nxt_s >= (SEL_W+1)'(NUM_SRC)) ? '0 : nxt_s[SEL_W-1:0];
            end else begin
                ptr_d = ptr_q;
            end
        end else if (load_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output stage and pointer registers.
    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) begin
            bus_q   <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            bus_q   <= bus_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign BUS_OUT   = bus_q;
    assign OUT_VALID = valid_q;
    assign OUT_SRC   = src_q;

`ifdef C_BUS_ARBITER_PARITY_EN
    logic par_q;

    // Parity follows the captured word; it changes only on a transfer.
    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) begin
            par_q <= 1'b0;
        end else if (xfer_s) begin
            par_q <= parity_f(IN_BUS[winner_s*BUS_WIDTH +: BUS_WIDTH]);
        end else begin
            par_q <= par_q;
        end
    end

    assign OUT_PARITY = par_q;
`endif

endmodule

// File: tb/tb_c_bus_arbiter.sv
// Directed bench for c_bus_arbiter: a fixed-priority and a round-robin instance share stimulus.
module tb_c_bus_arbiter;

    logic           clk;
    logic           rst;
    logic [3:0]     in_valid;
    logic [127:0]   in_bus;
    logic           ord;
    logic [3:0]     fp_rdy, rr_rdy;
    logic [31:0]    fp_bus, rr_bus;
    logic           fp_vld, rr_vld;
    logic [1:0]     fp_src, rr_src;
`ifdef C_BUS_ARBITER_PARITY_EN
    logic           fp_par, rr_par;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    c_bus_arbiter #(.BUS_WIDTH(32), .NUM_SRC(4), .SEL_W(2), .RR_EN(0)) dut_fp (
        .CLOCK_50(clk), .RESET_InHigh(rst), .IN_VALID(in_valid), .IN_BUS(in_bus),
        .IN_READY(fp_rdy), .BUS_OUT(fp_bus), .OUT_VALID(fp_vld), .OUT_READY(ord),
        .OUT_SRC(fp_src)
`ifdef C_BUS_ARBITER_PARITY_EN
        , .OUT_PARITY(fp_par)
`endif
    );

    c_bus_arbiter #(.BUS_WIDTH(32), .NUM_SRC(4), .SEL_W(2), .RR_EN(1)) dut_rr (
        .CLOCK_50(clk), .RESET_InHigh(rst), .IN_VALID(in_valid), .IN_BUS(in_bus),
        .IN_READY(rr_rdy), .BUS_OUT(rr_bus), .OUT_VALID(rr_vld), .OUT_READY(ord),
        .OUT_SRC(rr_src)
`ifdef C_BUS_ARBITER_PARITY_EN
        , .OUT_PARITY(rr_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic        o_rdy;
        logic [3:0]  exp_rdy;
        logic [31:0] exp_bus;
        logic        exp_vld;
        logic [1:0]  exp_src;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic default_data();
        in_bus = {32'h33333333, 32'h22222222, 32'h11111111, 32'h0A0A0A0A};
    endtask

    task automatic drive(input logic [3:0] v, input logic o);
        @(negedge clk);
        in_valid = v;
        ord      = o;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 4'b0000;
        ord      = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
    endtask

    initial begin
        logic [3:0] e_rdy;

        rst      = 1'b1;
        in_valid = 4'b0000;
        ord      = 1'b0;
        default_data();

        tbl[0] = '{4'b1010, 1'b1, 4'b0010, 32'h11111111, 1'b1, 2'd1};
        tbl[1] = '{4'b1000, 1'b1, 4'b1000, 32'h33333333, 1'b1, 2'd3};
        tbl[2] = '{4'b0000, 1'b1, 4'b0000, 32'h33333333, 1'b0, 2'd3};
        tbl[3] = '{4'b1111, 1'b1, 4'b0001, 32'h0A0A0A0A, 1'b1, 2'd0};
        tbl[4] = '{4'b1111, 1'b0, 4'b0000, 32'h0A0A0A0A, 1'b1, 2'd0};
        tbl[5] = '{4'b1100, 1'b0, 4'b0000, 32'h0A0A0A0A, 1'b1, 2'd0};
        tbl[6] = '{4'b1100, 1'b1, 4'b0100, 32'h22222222, 1'b1, 2'd2};
        tbl[7] = '{4'b0000, 1'b0, 4'b0000, 32'h22222222, 1'b1, 2'd2};
        tbl[8] = '{4'b0000, 1'b1, 4'b0000, 32'h22222222, 1'b0, 2'd2};
        tbl[9] = '{4'b0010, 1'b0, 4'b0010, 32'h11111111, 1'b1, 2'd1};

        // Reset state while held in reset.
        repeat (2) @(posedge clk);
        #1;
        in_valid = 4'b1111;
        #1;
        chk("rst_bus", fp_bus, 32'h0);
        chk("rst_vld", {31'd0, fp_vld}, 32'h0);
        chk("rst_src", {30'd0, fp_src}, 32'h0);
        chk("rst_rdy", {28'd0, fp_rdy}, 32'h0);
        do_reset();

        // Fixed-priority table.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].valid, tbl[i].o_rdy);
            chk($sformatf("fp_rdy[%0d]", i), {28'd0, fp_rdy}, {28'd0, tbl[i].exp_rdy});
            tick();
            chk($sformatf("fp_bus[%0d]", i), fp_bus, tbl[i].exp_bus);
            chk($sformatf("fp_vld[%0d]", i), {31'd0, fp_vld}, {31'd0, tbl[i].exp_vld});
            chk($sformatf("fp_src[%0d]", i), {30'd0, fp_src}, {30'd0, tbl[i].exp_src});
        end

        // Asynchronous reset mid-cycle with a word held.
        drive(4'b0100, 1'b1);
        tick();
        chk("pre_rst_vld", {31'd0, fp_vld}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_bus", fp_bus, 32'h0);
        chk("async_rst_vld", {31'd0, fp_vld}, 32'h0);
        chk("async_rst_src", {30'd0, fp_src}, 32'h0);
        chk("async_rst_rdy", {28'd0, fp_rdy}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin with all sources requesting.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(4'b1111, 1'b1);
            e_rdy = 4'b0001 << (k % 4);
            chk($sformatf("rr_rdy[%0d]", k), {28'd0, rr_rdy}, {28'd0, e_rdy});
            tick();
            chk($sformatf("rr_src[%0d]", k), {30'd0, rr_src}, 32'(k % 4));
            chk($sformatf("rr_vld[%0d]", k), {31'd0, rr_vld}, 32'h1);
        end

        // Drain to empty; pointer must be unchanged afterwards.
        drive(4'b0000, 1'b1);
        chk("rr_drain_rdy", {28'd0, rr_rdy}, 32'h0);
        tick();
        chk("rr_drain_vld", {31'd0, rr_vld}, 32'h0);
        chk("rr_drain_bus", rr_bus, 32'h11111111);
        chk("rr_drain_src", {30'd0, rr_src}, 32'h1);
        drive(4'b1111, 1'b1);
        chk("rr_ptr_kept", {28'd0, rr_rdy}, 32'h4);
        tick();
        chk("rr_src_2", {30'd0, rr_src}, 32'h2);
        drive(4'b1011, 1'b1);
        chk("rr_rdy_3", {28'd0, rr_rdy}, 32'h8);
        tick();
        chk("rr_src_3", {30'd0, rr_src}, 32'h3);
        drive(4'b1010, 1'b1);
        chk("rr_wrap_rdy", {28'd0, rr_rdy}, 32'h2);
        tick();
        chk("rr_wrap_src", {30'd0, rr_src}, 32'h1);

        // Back-pressure then release with no bubble.
        do_reset();
        in_bus[31:0] = 32'hDEADBEEF;
        drive(4'b0001, 1'b1);
        tick();
        chk("bp_load", fp_bus, 32'hDEADBEEF);
        for (int s = 0; s < 3; s++) begin
            drive(4'b0100, 1'b0);
            chk($sformatf("bp_rdy[%0d]", s), {28'd0, fp_rdy}, 32'h0);
            tick();
            chk($sformatf("bp_bus[%0d]", s), fp_bus, 32'hDEADBEEF);
            chk($sformatf("bp_vld[%0d]", s), {31'd0, fp_vld}, 32'h1);
        end
        drive(4'b0100, 1'b1);
        chk("bp_release_rdy", {28'd0, fp_rdy}, 32'h4);
        tick();
        chk("bp_release_bus", fp_bus, 32'h22222222);
        chk("bp_release_vld", {31'd0, fp_vld}, 32'h1);
        chk("bp_release_src", {30'd0, fp_src}, 32'h2);
        default_data();

`ifdef C_BUS_ARBITER_PARITY_EN
        do_reset();
        chk("par_rst", {31'd0, fp_par}, 32'h0);
        in_bus[31:0] = 32'h00000007;
        drive(4'b0001, 1'b1);
        tick();
        chk("par_7", {31'd0, fp_par}, 32'h1);
        in_bus[31:0] = 32'h00000003;
        drive(4'b0001, 1'b1);
        tick();
        chk("par_3", {31'd0, fp_par}, 32'h0);
        in_bus[31:0] = 32'h00000001;
        drive(4'b0000, 1'b1);
        tick();
        chk("par_hold", {31'd0, fp_par}, 32'h0);
        default_data();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
